crc32_frame_checker: RTL

- Receive-side companion to the byte-wise LUT CRC-32 generator.
- Accepts a byte stream carrying one frame: payload followed by a 4-byte FCS, least-significant byte first.
- Recomputes CRC-32 over the payload through a 256x32 lookup table and compares it with the received FCS.
- Reports a per-frame verdict and keeps saturating good/bad frame counters. Sits between the link byte receiver and frame consumers.

---
 rtl/crc32_frame_checker.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/crc32_frame_checker.sv
// rtl/crc32_frame_checker.sv - receive-side CRC-32 frame checker with verdict and frame counters
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   s_valid/s_data/s_last/s_ready  input byte stream (payload then 4-byte FCS, LSB first)
//   m_valid/m_ready                verdict handshake
//   m_ok, m_runt, m_crc, m_fcs,    verdict fields, held stable while m_valid=1
//   m_len
//   cnt_good, cnt_bad              saturating frame counters

module crc32_frame_checker #(
    parameter logic [31:0] POLY_REFL = 32'hEDB88320,
    parameter logic [31:0] INIT      = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT    = 32'hFFFFFFFF,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_ok,
    output logic             m_runt,
    output logic [31:0]      m_crc,
    output logic [31:0]      m_fcs,
    output logic [15:0]      m_len,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_bad
);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    function automatic logic [31:0] tab_entry(input int idx);
        logic [31:0] c;
        c = 32'(idx);
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    logic [31:0] tab [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_tab
        assign tab[gi] = tab_entry(gi);
    end

    state_t           state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [31:0]      dl_q, dl_d;          // newest byte in [31:24], oldest in [7:0]
    logic [2:0]       fill_q, fill_d;
    logic [15:0]      count_q, count_d;
    logic [31:0]      m_crc_q, m_crc_d;
    logic [31:0]      m_fcs_q, m_fcs_d;
    logic [15:0]      m_len_q, m_len_d;
    logic             m_ok_q, m_ok_d;
    logic             m_runt_q, m_runt_d;
    logic [CNT_W-1:0] cnt_good_q, cnt_good_d;
    logic [CNT_W-1:0] cnt_bad_q, cnt_bad_d;

    // The first byte after IDLE starts a fresh frame, so the working
    // registers are replaced by their start values for that byte.
    logic        frame_start;
    logic [31:0] crc_base, dl_base, crc_upd, dl_shift, crc_final;
    logic [2:0]  fill_base, fill_inc;
    logic [15:0] count_base, count_inc;
    logic        runt_new, accept;

    always_comb begin
        accept      = s_valid && (state_q != REPORT);
        frame_start = (state_q == IDLE);
        crc_base    = frame_start ? INIT  : crc_q;
        dl_base     = frame_start ? '0    : dl_q;
        fill_base   = frame_start ? 3'd0  : fill_q;
        count_base  = frame_start ? 16'd0 : count_q;

        // Only a byte leaving a full delay line is payload; the last four
        // bytes seen are always the candidate FCS.
        crc_upd   = (fill_base == 3'd4)
                  ? (tab[crc_base[7:0] ^ dl_base[7:0]] ^ (crc_base >> 8))
                  : crc_base;
        dl_shift  = {s_data, dl_base[31:8]};
        fill_inc  = (fill_base == 3'd4) ? 3'd4 : fill_base + 3'd1;
        count_inc = (count_base == 16'hFFFF) ? 16'hFFFF : count_base + 16'd1;
        crc_final = crc_upd ^ XOROUT;
        runt_new  = (count_inc < 16'd5);

        state_d    = state_q;
        crc_d      = crc_q;
        dl_d       = dl_q;
        fill_d     = fill_q;
        count_d    = count_q;
        m_crc_d    = m_crc_q;
        m_fcs_d    = m_fcs_q;
        m_len_d    = m_len_q;
        m_ok_d     = m_ok_q;
        m_runt_d   = m_runt_q;
        cnt_good_d = cnt_good_q;
        cnt_bad_d  = cnt_bad_q;

        case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    crc_d   = crc_upd;
                    dl_d    = dl_shift;
                    fill_d  = fill_inc;
                    count_d = count_inc;
                    if (s_last) begin
                        state_d  = REPORT;
                        m_crc_d  = crc_final;
                        m_fcs_d  = dl_shift;
                        m_len_d  = count_inc;
                        m_runt_d = runt_new;
                        m_ok_d   = !runt_new && (crc_final == dl_shift);
                        if (!runt_new && (crc_final == dl_shift)) begin
                            if (!(&cnt_good_q)) cnt_good_d = cnt_good_q + CNT_W'(1);
                        end else begin
                            if (!(&cnt_bad_q)) cnt_bad_d = cnt_bad_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            REPORT: begin
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            crc_q      <= INIT;
            dl_q       <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            m_crc_q    <= '0;
            m_fcs_q    <= '0;
            m_len_q    <= '0;
            m_ok_q     <= 1'b0;
            m_runt_q   <= 1'b0;
            cnt_good_q <= '0;
            cnt_bad_q  <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            dl_q       <= dl_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            m_crc_q    <= m_crc_d;
            m_fcs_q    <= m_fcs_d;
            m_len_q    <= m_len_d;
            m_ok_q     <= m_ok_d;
            m_runt_q   <= m_runt_d;
            cnt_good_q <= cnt_good_d;
            cnt_bad_q  <= cnt_bad_d;
        end
    end

    assign s_ready  = (state_q != REPORT);
    assign m_valid  = (state_q == REPORT);
    assign m_ok     = m_ok_q;
    assign m_runt   = m_runt_q;
    assign m_crc    = m_crc_q;
    assign m_fcs    = m_fcs_q;
    assign m_len    = m_len_q;
    assign cnt_good = cnt_good_q;
    assign cnt_bad  = cnt_bad_q;

endmodule
